// File: rtl/sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sseg_scan_ctrl
//  Purpose  : Time-multiplexing scan controller for a bank of common-bus
//             seven-segment digits. It holds an active frame of nibbles,
//             decimal points and digit enables, steps through the digits at
//             a fixed slot rate and drives the shared nibble/dp to the
//             decoder while one-hot selecting the current digit. New frames
//             arrive through a valid/ready handshake into a pending buffer
//             and are only promoted on frame boundaries.
//  Ports    : clk          - system clock
//             reset        - asynchronous active-high reset
//             load_hex     - nibble per digit, digit k = [4k+3:4k]
//             load_dp      - decimal point per digit
//             load_en      - digit enable per digit
//             load_valid   - frame offered
//             load_ready   - pending buffer empty
//             hex_out      - nibble of the current digit
//             dp_out       - decimal point of the current digit
//             an           - one-hot digit select, active-high
//             frame_start  - one-cycle pulse at the first cycle of digit 0
//  Revision : 1.0 - initial release
// ============================================================================
module sseg_scan_ctrl #(
    parameter int N_DIGITS     = 4,
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] load_hex,
    input  logic [N_DIGITS-1:0]   load_dp,
    input  logic [N_DIGITS-1:0]   load_en,
    input  logic                  load_valid,
    output logic                  load_ready,
    output logic [3:0]            hex_out,
    output logic                  dp_out,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_start
);

    localparam int c_CNT_W = $clog2(SLOT_CYCLES);
    localparam int c_IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(SLOT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK   = c_CNT_W'(BLANK_CYCLES);
    localparam logic [c_IDX_W-1:0] c_IDX_MAX = c_IDX_W'(N_DIGITS - 1);

    // Scan position
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_IDX_W-1:0]    r_idx;

    // Frame currently on display
    logic [4*N_DIGITS-1:0] r_act_hex;
    logic [N_DIGITS-1:0]   r_act_dp;
    logic [N_DIGITS-1:0]   r_act_en;

    // Frame waiting for the next boundary
    logic [4*N_DIGITS-1:0] r_pend_hex;
    logic [N_DIGITS-1:0]   r_pend_dp;
    logic [N_DIGITS-1:0]   r_pend_en;
    logic                  r_pend_full;

    logic                  r_frame_start;

    logic                  w_slot_end;
    logic                  w_boundary;
    logic                  w_accept;
    logic [N_DIGITS-1:0]   w_an;
    logic [3:0]            w_hex;
    logic                  w_dp;

    assign w_slot_end = (r_cnt == c_CNT_MAX);
    assign w_boundary = w_slot_end && (r_idx == c_IDX_MAX);
    assign w_accept   = load_valid && !r_pend_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt         <= '0;
            r_idx         <= '0;
            r_act_hex     <= '0;
            r_act_dp      <= '0;
            r_act_en      <= '0;
            r_pend_hex    <= '0;
            r_pend_dp     <= '0;
            r_pend_en     <= '0;
            r_pend_full   <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= (r_idx == c_IDX_MAX) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            // The cycle after a boundary is exactly cnt=0/idx=0. Registering
            // the pulse this way keeps it low in the first cycle after reset.
            r_frame_start <= w_boundary;

            // Promotion uses pending_full as it stood at the start of the
            // cycle, so a frame accepted on the boundary waits a full frame.
            if (w_boundary && r_pend_full) begin
                r_act_hex   <= r_pend_hex;
                r_act_dp    <= r_pend_dp;
                r_act_en    <= r_pend_en;
                r_pend_full <= 1'b0;
            end

            // Acceptance only happens while pending is empty, so it never
            // collides with the promotion above.
            if (w_accept) begin
                r_pend_hex  <= load_hex;
                r_pend_dp   <= load_dp;
                r_pend_en   <= load_en;
                r_pend_full <= 1'b1;
            end
        end
    end

    // Output decode from registered state only
    always_comb begin
        w_hex = r_act_hex[{r_idx, 2'b00} +: 4];
        w_dp  = r_act_dp[r_idx];
        w_an  = '0;
        if ((r_cnt >= c_BLANK) && r_act_en[r_idx]) begin
            w_an[r_idx] = 1'b1;
        end
    end

    assign load_ready  = !r_pend_full;
    assign hex_out     = w_hex;
    assign dp_out      = w_dp;
    assign an          = w_an;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sseg_scan_ctrl
//  Purpose  : Self-checking bench for sseg_scan_ctrl with N_DIGITS=4,
//             SLOT_CYCLES=8, BLANK_CYCLES=2 (frame = 32 cycles). Directed
//             vectors are kept in a table keyed by scenario and cycle number
//             since reset release; idle and reset-mid-frame cases are coded
//             as short hand-written sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sseg_scan_ctrl;

    localparam int c_N     = 4;
    localparam int c_SLOT  = 8;
    localparam int c_BLANK = 2;

    logic              clk;
    logic              reset;
    logic [4*c_N-1:0]  load_hex;
    logic [c_N-1:0]    load_dp;
    logic [c_N-1:0]    load_en;
    logic              load_valid;
    logic              load_ready;
    logic [3:0]        hex_out;
    logic              dp_out;
    logic [c_N-1:0]    an;
    logic              frame_start;

    sseg_scan_ctrl #(
        .N_DIGITS     (c_N),
        .SLOT_CYCLES  (c_SLOT),
        .BLANK_CYCLES (c_BLANK)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .load_hex    (load_hex),
        .load_dp     (load_dp),
        .load_en     (load_en),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .hex_out     (hex_out),
        .dp_out      (dp_out),
        .an          (an),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          sc;     // scenario id; a change forces a fresh reset
        int          t;      // cycle number since reset release
        logic        drv;    // apply the input fields after checking
        logic        v;
        logic [15:0] h;
        logic [3:0]  d;
        logic [3:0]  e;
        logic [3:0]  x_hex;
        logic        x_dp;
        logic [3:0]  x_an;
        logic        x_rdy;
        logic        x_fs;
    } vec_t;

    vec_t vecs[$];

    int n_checks = 0;
    int n_fail   = 0;
    int t        = 0;
    int cur_sc   = -1;

    task automatic add(input int sc, input int tt, input logic drv,
                       input logic v, input logic [15:0] h, input logic [3:0] d,
                       input logic [3:0] e, input logic [3:0] xh, input logic xd,
                       input logic [3:0] xa, input logic xr, input logic xf);
        vec_t r;
        r.sc = sc; r.t = tt; r.drv = drv; r.v = v; r.h = h; r.d = d; r.e = e;
        r.x_hex = xh; r.x_dp = xd; r.x_an = xa; r.x_rdy = xr; r.x_fs = xf;
        vecs.push_back(r);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s (scenario %0d, t=%0d): got %0h, expected %0h",
                     name, cur_sc, t, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        load_valid = 1'b0;
        load_hex   = '0;
        load_dp    = '0;
        load_en    = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        t     = 0;
    endtask

    task automatic drive(input logic v, input logic [15:0] h,
                         input logic [3:0] d, input logic [3:0] e);
        load_valid = v;
        load_hex   = h;
        load_dp    = d;
        load_en    = e;
    endtask

    initial begin
        reset      = 1'b1;
        load_valid = 1'b0;
        load_hex   = '0;
        load_dp    = '0;
        load_en    = '0;

        // Scenario 2: single load, full per-digit walk
        add(2, 0, 1, 1, 16'h4321, 4'b0001, 4'hF, 4'h0, 0, 4'b0000, 1, 0);
        add(2, 1, 1, 0, 16'h4321, 4'b0001, 4'hF, 4'h0, 0, 4'b0000, 0, 0);
        add(2, 31, 0, 0, 0, 0, 0,                4'h0, 0, 4'b0000, 0, 0);
        add(2, 32, 0, 0, 0, 0, 0,                4'h1, 1, 4'b0000, 1, 1);
        add(2, 33, 0, 0, 0, 0, 0,                4'h1, 1, 4'b0000, 1, 0);
        add(2, 34, 0, 0, 0, 0, 0,                4'h1, 1, 4'b0001, 1, 0);
        add(2, 39, 0, 0, 0, 0, 0,                4'h1, 1, 4'b0001, 1, 0);
        add(2, 40, 0, 0, 0, 0, 0,                4'h2, 0, 4'b0000, 1, 0);
        add(2, 42, 0, 0, 0, 0, 0,                4'h2, 0, 4'b0010, 1, 0);
        add(2, 48, 0, 0, 0, 0, 0,                4'h3, 0, 4'b0000, 1, 0);
        add(2, 50, 0, 0, 0, 0, 0,                4'h3, 0, 4'b0100, 1, 0);
        add(2, 56, 0, 0, 0, 0, 0,                4'h4, 0, 4'b0000, 1, 0);
        add(2, 58, 0, 0, 0, 0, 0,                4'h4, 0, 4'b1000, 1, 0);
        add(2, 63, 0, 0, 0, 0, 0,                4'h4, 0, 4'b1000, 1, 0);
        add(2, 64, 0, 0, 0, 0, 0,                4'h1, 1, 4'b0000, 1, 1);

        // Scenario 3: back-to-back loads with valid held high
        add(3, 0, 1, 1, 16'h1111, 4'b0000, 4'hF, 4'h0, 0, 4'b0000, 1, 0);
        add(3, 1, 1, 1, 16'h2222, 4'b0000, 4'hF, 4'h0, 0, 4'b0000, 0, 0);
        add(3, 31, 0, 0, 0, 0, 0,                4'h0, 0, 4'b0000, 0, 0);
        add(3, 32, 0, 0, 0, 0, 0,                4'h1, 0, 4'b0000, 1, 1);
        add(3, 33, 1, 0, 16'h2222, 4'b0000, 4'hF, 4'h1, 0, 4'b0000, 0, 0);
        add(3, 34, 0, 0, 0, 0, 0,                4'h1, 0, 4'b0001, 0, 0);
        add(3, 40, 0, 0, 0, 0, 0,                4'h1, 0, 4'b0000, 0, 0);
        add(3, 63, 0, 0, 0, 0, 0,                4'h1, 0, 4'b1000, 0, 0);
        add(3, 64, 0, 0, 0, 0, 0,                4'h2, 0, 4'b0000, 1, 1);
        add(3, 66, 0, 0, 0, 0, 0,                4'h2, 0, 4'b0001, 1, 0);
        add(3, 74, 0, 0, 0, 0, 0,                4'h2, 0, 4'b0010, 1, 0);

        // Scenario 4: partial digit enables
        add(4, 0, 1, 1, 16'h4321, 4'b0000, 4'b0101, 4'h0, 0, 4'b0000, 1, 0);
        add(4, 1, 1, 0, 16'h4321, 4'b0000, 4'b0101, 4'h0, 0, 4'b0000, 0, 0);
        add(4, 32, 0, 0, 0, 0, 0,                4'h1, 0, 4'b0000, 1, 1);
        add(4, 34, 0, 0, 0, 0, 0,                4'h1, 0, 4'b0001, 1, 0);
        add(4, 42, 0, 0, 0, 0, 0,                4'h2, 0, 4'b0000, 1, 0);
        add(4, 47, 0, 0, 0, 0, 0,                4'h2, 0, 4'b0000, 1, 0);
        add(4, 50, 0, 0, 0, 0, 0,                4'h3, 0, 4'b0100, 1, 0);
        add(4, 58, 0, 0, 0, 0, 0,                4'h4, 0, 4'b0000, 1, 0);
        add(4, 63, 0, 0, 0, 0, 0,                4'h4, 0, 4'b0000, 1, 0);

        // Scenario 5: frame offered exactly on the boundary cycle
        add(5, 0, 1, 1, 16'h4321, 4'b0000, 4'hF, 4'h0, 0, 4'b0000, 1, 0);
        add(5, 1, 1, 0, 16'h4321, 4'b0000, 4'hF, 4'h0, 0, 4'b0000, 0, 0);
        add(5, 63, 1, 1, 16'hAAAA, 4'b0000, 4'hF, 4'h4, 0, 4'b1000, 1, 0);
        add(5, 64, 1, 0, 16'hAAAA, 4'b0000, 4'hF, 4'h1, 0, 4'b0000, 0, 1);
        add(5, 95, 0, 0, 0, 0, 0,                4'h4, 0, 4'b1000, 0, 0);
        add(5, 96, 0, 0, 0, 0, 0,                4'hA, 0, 4'b0000, 1, 1);
        add(5, 98, 0, 0, 0, 0, 0,                4'hA, 0, 4'b0001, 1, 0);

        // Scenario 1: reset state and idle scanning
        cur_sc = 1;
        do_reset();
        check("reset_an",    int'(an), 0);
        check("reset_hex",   int'(hex_out), 0);
        check("reset_dp",    int'(dp_out), 0);
        check("reset_ready", int'(load_ready), 1);
        check("reset_fs",    int'(frame_start), 0);
        for (int i = 1; i <= 40; i++) begin
            step();
            check("idle_an",    int'(an), 0);
            check("idle_hex",   int'(hex_out), 0);
            check("idle_ready", int'(load_ready), 1);
            check("idle_fs",    int'(frame_start), ((t % 32) == 0) ? 1 : 0);
        end

        // Table-driven scenarios
        foreach (vecs[k]) begin
            if (vecs[k].sc != cur_sc) begin
                cur_sc = vecs[k].sc;
                do_reset();
            end
            while (t < vecs[k].t) step();
            check("hex_out",     int'(hex_out),     int'(vecs[k].x_hex));
            check("dp_out",      int'(dp_out),      int'(vecs[k].x_dp));
            check("an",          int'(an),          int'(vecs[k].x_an));
            check("load_ready",  int'(load_ready),  int'(vecs[k].x_rdy));
            check("frame_start", int'(frame_start), int'(vecs[k].x_fs));
            if (vecs[k].drv) drive(vecs[k].v, vecs[k].h, vecs[k].d, vecs[k].e);
        end

        // Scenario 6: reset mid-frame with a pending frame
        cur_sc = 6;
        do_reset();
        drive(1'b1, 16'h4321, 4'b0000, 4'hF);
        step();
        drive(1'b0, 16'h4321, 4'b0000, 4'hF);
        while (t < 33) step();
        drive(1'b1, 16'hBBBB, 4'b1111, 4'hF);
        step();
        drive(1'b0, 16'hBBBB, 4'b1111, 4'hF);
        check("pend_ready", int'(load_ready), 0);
        while (t < 53) step();
        check("pre_rst_an",  int'(an), 4'b0100);
        check("pre_rst_hex", int'(hex_out), 3);
        #1 reset = 1'b1;
        #1;
        check("async_rst_an",    int'(an), 0);
        check("async_rst_hex",   int'(hex_out), 0);
        check("async_rst_dp",    int'(dp_out), 0);
        check("async_rst_ready", int'(load_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        t     = 0;
        for (int i = 0; i < 70; i++) begin
            step();
            check("post_rst_an",  int'(an), 0);
            check("post_rst_hex", int'(hex_out), 0);
            check("post_rst_dp",  int'(dp_out), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
